// File: rtl/decode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_pkg
//  Description : Shared types and constants for the decode_ctrl block:
//                opcode enum, FSM state enum, instruction field positions,
//                decoded-opcode record and default datapath width.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_ctrl_pkg;

    localparam int c_DEFAULT_BITS = 8;

    // Instruction word layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int c_INSTR_W = 16;
    localparam int c_OPC_MSB = 15;
    localparam int c_OPC_LSB = 12;
    localparam int c_RD_MSB  = 11;
    localparam int c_RD_LSB  = 10;
    localparam int c_RS_MSB  = 9;
    localparam int c_RS_LSB  = 8;
    localparam int c_IMM_MSB = 7;
    localparam int c_IMM_LSB = 0;
    localparam int c_IMM_W   = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ALU0 = 4'h2,
        OP_ALU1 = 4'h3,
        OP_ALU2 = 4'h4,
        OP_ALU3 = 4'h5,
        OP_ALU4 = 4'h6,
        OP_ALU5 = 4'h7,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    typedef struct packed {
        logic       is_alu;
        logic       is_ldi;
        logic       is_hlt;
        logic       is_illegal;
        logic [2:0] alu_op;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_if
//  Description : Instruction handshake and decode-output bundle.
//                master : instruction source (drives instr_valid/instr)
//                slave  : decode_ctrl (drives ready and all decode outputs)
//  Ports       : instr_valid, instr[15:0], instr_ready, S_reg,
//                custom_input[BITS-1:0], alu_op[2:0], rd_addr[1:0],
//                rs_addr[1:0], alu_en, reg_we, halted, illegal_err
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_ctrl_if #(
    parameter int BITS = decode_ctrl_pkg::c_DEFAULT_BITS
);
    logic            instr_valid;
    logic [15:0]     instr;
    logic            instr_ready;
    logic            S_reg;
    logic [BITS-1:0] custom_input;
    logic [2:0]      alu_op;
    logic [1:0]      rd_addr;
    logic [1:0]      rs_addr;
    logic            alu_en;
    logic            reg_we;
    logic            halted;
    logic            illegal_err;

    modport master (
        output instr_valid, instr,
        input  instr_ready, S_reg, custom_input, alu_op, rd_addr, rs_addr,
               alu_en, reg_we, halted, illegal_err
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, S_reg, custom_input, alu_op, rd_addr, rs_addr,
               alu_en, reg_we, halted, illegal_err
    );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_rom.sv
`default_nettype none
// ============================================================================
//  Module      : decode_rom
//  Description : Combinational opcode classifier. Maps a 4-bit opcode to
//                {is_alu, is_ldi, is_hlt, is_illegal, alu_op}.
//  Ports       : i_opcode[3:0] -> o_dec (dec_t)
//  Revision    : 1.0  initial release
// ============================================================================
module decode_rom
    import decode_ctrl_pkg::*;
(
    input  wire logic [3:0] i_opcode,
    output dec_t            o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_NOP: ;
            OP_LDI: o_dec.is_ldi = 1'b1;
            OP_HLT: o_dec.is_hlt = 1'b1;
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3, OP_ALU4, OP_ALU5: begin
                o_dec.is_alu = 1'b1;
                // Opcodes 2..7 have bit 3 clear, so the low three bits
                // minus two give ALU codes 0..5 without wrap.
                o_dec.alu_op = i_opcode[2:0] - 3'd2;
            end
            default: o_dec.is_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl
//  Description : Multi-cycle instruction decode controller. Accepts one
//                instruction in IDLE, then walks DECODE -> EXEC -> WB,
//                issuing an ALU strobe in EXEC and a register write strobe
//                in WB. HLT parks the FSM in HALT until reset.
//  Ports       : clk, rst_n (sync, active-low), bus (decode_ctrl_if.slave)
//  Config      : DECODE_ILLEGAL_TRAP_EN - when defined, illegal opcodes set
//                a sticky illegal_err and halt; otherwise they act as NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int BITS = c_DEFAULT_BITS
)(
    input  wire logic     clk,
    input  wire logic     rst_n,
    decode_ctrl_if.slave  bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_INSTR_W-1:0]  r_instr;
    dec_t                  w_dec;
    logic                  w_ready;
    logic                  w_alu_en;
    logic                  w_reg_we;
    logic                  w_halted;
    logic                  w_accept;
    logic [c_IMM_W-1:0]    w_imm;

    assign w_accept = w_ready && bus.instr_valid;
    assign w_imm    = r_instr[c_IMM_MSB:c_IMM_LSB];

    decode_rom u_rom (
        .i_opcode (r_instr[c_OPC_MSB:c_OPC_LSB]),
        .o_dec    (w_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // instr is only sampled on an accept, so traffic while busy is ignored.
    // Clearing on reset makes the decoded fields read as a NOP with zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= bus.instr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_alu_en    = 1'b0;
        w_reg_we    = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec.is_hlt) begin
                    w_state_nxt = S_HALT;
                end else if (w_dec.is_illegal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    w_state_nxt = S_HALT;
`else
                    w_state_nxt = S_IDLE;
`endif
                end else if (w_dec.is_alu || w_dec.is_ldi) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                w_alu_en    = w_dec.is_alu;
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_reg_we    = w_dec.is_alu || w_dec.is_ldi;
                w_state_nxt = S_IDLE;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_illegal_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal_err <= 1'b0;
        end else if ((r_state == S_DECODE) && w_dec.is_illegal) begin
            r_illegal_err <= 1'b1;
        end
    end

    assign bus.illegal_err = r_illegal_err;
`else
    assign bus.illegal_err = 1'b0;
`endif

    // Immediate widened (zero-extended) or narrowed to the datapath width.
    if (BITS > c_IMM_W) begin : g_imm_zext
        assign bus.custom_input = {{(BITS - c_IMM_W){1'b0}}, w_imm};
    end else begin : g_imm_fit
        assign bus.custom_input = w_imm[BITS-1:0];
    end

    // Decode fields come straight from the latched word, so they are valid
    // from DECODE and stay stable until the next accept.
    assign bus.instr_ready = w_ready;
    assign bus.S_reg       = w_dec.is_ldi;
    assign bus.alu_op      = w_dec.alu_op;
    assign bus.rd_addr     = r_instr[c_RD_MSB:c_RD_LSB];
    assign bus.rs_addr     = r_instr[c_RS_MSB:c_RS_LSB];
    assign bus.alu_en      = w_alu_en;
    assign bus.reg_we      = w_reg_we;
    assign bus.halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_ctrl
//  Description : Self-checking bench for decode_ctrl. Directed instruction
//                sequence; the expected decode of each accepted instruction
//                is queued at accept time and consumed while the DUT steps
//                through DECODE/EXEC/WB (or HALT).
//  Config      : honours DECODE_ILLEGAL_TRAP_EN for illegal-opcode checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_ctrl_if #(.BITS(8)) bus ();

    decode_ctrl #(.BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] instr;
        logic        s_reg;
        logic [7:0]  imm;
        logic [2:0]  alu_op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic        alu_en;
        logic        we;
        logic        hlt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_cnt   = 0;

    always @(posedge clk) if (bus.reg_we === 1'b1) we_cnt <= we_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [15:0] ins);
        exp_t       e;
        logic [3:0] op;
        op       = ins[15:12];
        e.instr  = ins;
        e.hlt    = (op == 4'hF);
        e.ill    = (op >= 4'h8) && (op <= 4'hE);
        e.alu_en = (op >= 4'h2) && (op <= 4'h7);
        e.s_reg  = (op == 4'h1);
        e.imm    = ins[7:0];
        e.alu_op = e.alu_en ? 3'(op - 4'h2) : 3'd0;
        e.rd     = ins[11:10];
        e.rs     = ins[9:8];
        e.we     = e.alu_en || e.s_reg;
        return e;
    endfunction

    task automatic chk_reset();
        chk("rst_ready",  bus.instr_ready,  1);
        chk("rst_sreg",   bus.S_reg,        0);
        chk("rst_custom", bus.custom_input, 0);
        chk("rst_aluop",  bus.alu_op,       0);
        chk("rst_rd",     bus.rd_addr,      0);
        chk("rst_rs",     bus.rs_addr,      0);
        chk("rst_aluen",  bus.alu_en,       0);
        chk("rst_regwe",  bus.reg_we,       0);
        chk("rst_halted", bus.halted,       0);
        chk("rst_illerr", bus.illegal_err,  0);
    endtask

    // Present ins and wait (bounded) for the accept edge; exp_wait is the
    // number of idle-wait cycles expected before ready is seen.
    task automatic send(input logic [15:0] ins, input bit hold, input int exp_wait);
        int waited;
        waited          = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        while (bus.instr_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("accept_wait", waited, exp_wait);
        tick();
        sb.push_back(model(ins));
        if (!hold) bus.instr_valid = 1'b0;
    endtask

    // Called in the DECODE cycle right after an accept.
    task automatic follow();
        exp_t e;
        int   we0;
        bit   go_halt;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e   = sb.pop_front();
        we0 = we_cnt;
        chk("dec_ready",  bus.instr_ready,  0);
        chk("dec_sreg",   bus.S_reg,        e.s_reg);
        chk("dec_custom", bus.custom_input, e.imm);
        chk("dec_aluop",  bus.alu_op,       e.alu_op);
        chk("dec_rd",     bus.rd_addr,      e.rd);
        chk("dec_rs",     bus.rs_addr,      e.rs);
        chk("dec_aluen",  bus.alu_en,       0);
        chk("dec_regwe",  bus.reg_we,       0);
        go_halt = e.hlt;
`ifdef DECODE_ILLEGAL_TRAP_EN
        go_halt = go_halt || e.ill;
`endif
        if (go_halt) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("halt_halted", bus.halted,      1);
                chk("halt_ready",  bus.instr_ready, 0);
                chk("halt_regwe",  bus.reg_we,      0);
            end
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk("halt_illerr", bus.illegal_err, e.ill);
`else
            chk("halt_illerr", bus.illegal_err, 0);
`endif
        end else if (e.we) begin
            tick();
            chk("exec_aluen",  bus.alu_en,       e.alu_en);
            chk("exec_regwe",  bus.reg_we,       0);
            chk("exec_ready",  bus.instr_ready,  0);
            chk("exec_sreg",   bus.S_reg,        e.s_reg);
            chk("exec_custom", bus.custom_input, e.imm);
            tick();
            chk("wb_regwe",  bus.reg_we,  1);
            chk("wb_aluen",  bus.alu_en,  0);
            chk("wb_aluop",  bus.alu_op,  e.alu_op);
            chk("wb_rd",     bus.rd_addr, e.rd);
            chk("wb_rs",     bus.rs_addr, e.rs);
            tick();
            chk("post_ready",  bus.instr_ready, 1);
            chk("post_regwe",  bus.reg_we,      0);
            chk("we_pulses",   we_cnt - we0,    1);
        end else begin
            tick();
            chk("nop_ready",  bus.instr_ready, 1);
            chk("nop_aluen",  bus.alu_en,      0);
            chk("nop_pulses", we_cnt - we0,    0);
            chk("nop_illerr", bus.illegal_err, 0);
            chk("nop_halted", bus.halted,      0);
        end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset();
        tick();
        chk("idle_hold_ready", bus.instr_ready, 1);

        // LDI rd=1 imm=0xA5
        send(16'h14A5, 1'b0, 0);
        follow();

        // ALU opcode 3, rd=2, rs=1
        send(16'h3900, 1'b0, 0);
        follow();

        // NOP with valid held; second instruction accepted right after
        // DECODE; junk on instr while busy must not be sampled
        send(16'h0000, 1'b1, 0);
        bus.instr = 16'h2E40;
        follow();
        send(16'h2E40, 1'b1, 0);
        bus.instr = 16'h1FFF;
        follow();
        bus.instr_valid = 1'b0;

        // Highest ALU opcode, all-ones immediate
        send(16'h7DFF, 1'b0, 0);
        follow();

        // Reset during EXEC aborts the write-back
        begin
            int we0;
            we0 = we_cnt;
            send(16'h3900, 1'b0, 0);
            void'(sb.pop_front());
            tick();
            chk("abort_exec_aluen", bus.alu_en, 1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("abort_ready", bus.instr_ready, 1);
            chk("abort_regwe", bus.reg_we,      0);
            tick();
            tick();
            chk("abort_regwe_late", bus.reg_we,   0);
            chk("abort_pulses",     we_cnt - we0, 0);
        end

        // HLT, then a one-edge reset
        send(16'hF000, 1'b0, 0);
        follow();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset();

        // Illegal opcode 0x9
        send(16'h9000, 1'b0, 0);
        follow();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset();

        // Recovery after reset
        send(16'h14A5, 1'b0, 0);
        follow();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
